// File: rtl/easy_fifo_pkg.sv
// Shared types for the FIFO write-side arbiter.
package easy_fifo_pkg;

  // Arbiter FSM: waiting for a requester, or a requester owns the FIFO write port.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Widest requester index supported (NUM_REQ <= 16).
  localparam int unsigned MAX_NUM_REQ = 16;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the search starts just after i_last_grant and wraps,
// so i_last_grant itself has the lowest priority.
module rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_last_grant,
  output logic [IDX_W-1:0]   o_winner,
  output logic               o_any_valid
);

  logic [IDX_W-1:0] w_idx;

  // First set request bit in rotated order wins.
  always_comb begin
    o_winner    = i_last_grant;
    o_any_valid = 1'b0;
    w_idx       = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      w_idx = IDX_W'((32'(i_last_grant) + k) % NUM_REQ);
      if (!o_any_valid && i_req[w_idx]) begin
        o_winner    = w_idx;
        o_any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that lets NUM_REQ requesters take turns writing bursts of up to
// MAX_BURST beats into a shared sync FIFO write port.
module fifo_wr_arbiter
  import easy_fifo_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DWIDTH    = 32,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ*DWIDTH-1:0]   req_data,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [DWIDTH-1:0]           fifo_wr_data,
  output logic                        fifo_wr_en,
  input  logic                        fifo_wr_full,
  output logic                        grant_active,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);
  localparam logic [IDX_W-1:0] RST_ID    = IDX_W'(NUM_REQ - 1);

  if (NUM_REQ < 2 || NUM_REQ > MAX_NUM_REQ) begin : g_bad_num_req
    $error("fifo_wr_arbiter: NUM_REQ must be in 2..16");
  end
  if (MAX_BURST < 1 || MAX_BURST > 256) begin : g_bad_max_burst
    $error("fifo_wr_arbiter: MAX_BURST must be in 1..256");
  end

  arb_state_e       r_state, w_state_nxt;
  logic [IDX_W-1:0] r_grant_id, w_grant_id_nxt;
  logic [IDX_W-1:0] r_last_grant, w_last_grant_nxt;
  logic [CNT_W-1:0] r_beat_cnt, w_beat_cnt_nxt;
  logic [IDX_W-1:0] w_pick_last;
  logic [IDX_W-1:0] w_winner;
  logic             w_any_valid;
  logic             w_in_grant;
  logic             w_gnt_valid;
  logic             w_accept;
  logic             w_release;

  assign w_in_grant  = (r_state == GRANT);
  assign w_gnt_valid = req_valid[r_grant_id];
  // A beat moves only when the grantee offers data and the FIFO has room.
  assign w_accept    = w_in_grant & w_gnt_valid & ~fifo_wr_full;
  // Release on the last beat of a burst, or as soon as the grantee stops offering data.
  assign w_release   = w_in_grant & (~w_gnt_valid | (w_accept & (r_beat_cnt == LAST_BEAT)));

  // While granted, re-arbitration treats the current grantee as last_grant, so it only
  // wins again when nobody else is requesting.
  assign w_pick_last = w_in_grant ? r_grant_id : r_last_grant;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .i_req        (req_valid),
    .i_last_grant (w_pick_last),
    .o_winner     (w_winner),
    .o_any_valid  (w_any_valid)
  );

  // Next-state: arbitrate from IDLE, count beats, hand over with no bubble on release.
  always_comb begin
    w_state_nxt      = r_state;
    w_grant_id_nxt   = r_grant_id;
    w_last_grant_nxt = r_last_grant;
    w_beat_cnt_nxt   = r_beat_cnt;
    case (r_state)
      IDLE: begin
        if (w_any_valid) begin
          w_state_nxt    = GRANT;
          w_grant_id_nxt = w_winner;
          w_beat_cnt_nxt = '0;
        end
      end
      GRANT: begin
        if (w_release) begin
          w_last_grant_nxt = r_grant_id;
          if (w_any_valid) begin
            w_grant_id_nxt = w_winner;
            w_beat_cnt_nxt = '0;
          end else begin
            w_state_nxt = IDLE;
          end
        end else if (w_accept) begin
          w_beat_cnt_nxt = r_beat_cnt + 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State registers; reset leaves requester 0 with first priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_grant_id   <= RST_ID;
      r_last_grant <= RST_ID;
      r_beat_cnt   <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_grant_id   <= w_grant_id_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_beat_cnt   <= w_beat_cnt_nxt;
    end
  end

  // Only the grantee sees ready, and only while the FIFO has room.
  always_comb begin
    req_ready = '0;
    if (w_in_grant && !fifo_wr_full) begin
      req_ready[r_grant_id] = 1'b1;
    end
  end

  assign fifo_wr_en   = w_accept;
  assign fifo_wr_data = req_data[32'(r_grant_id) * DWIDTH +: DWIDTH];
  assign grant_active = w_in_grant;
  assign grant_id     = r_grant_id;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: per-requester data scoreboard, expected grant
// segments (grantee, beats), directed scenarios and a randomized run with a fairness bound.
module tb_fifo_wr_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int DWIDTH    = 32;
  localparam int MAX_BURST = 4;
  localparam int IW        = $clog2(NUM_REQ);
  localparam int BOUND     = (NUM_REQ - 1) * MAX_BURST;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NUM_REQ*DWIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [DWIDTH-1:0]         fifo_wr_data;
  logic                      fifo_wr_en;
  logic                      fifo_wr_full;
  logic                      grant_active;
  logic [IW-1:0]             grant_id;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .DWIDTH    (DWIDTH),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_data     (req_data),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .fifo_wr_data (fifo_wr_data),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_full (fifo_wr_full),
    .grant_active (grant_active),
    .grant_id     (grant_id)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Stimulus and scoreboard state.
  logic [DWIDTH-1:0] src_q [NUM_REQ][$];
  logic [DWIDTH-1:0] exp_q [NUM_REQ][$];
  int                exp_seg_q[$];
  bit                full_script[$];
  int                gate_pct = 100;
  int                full_pct = 0;
  int                seq = 0;
  logic [NUM_REQ-1:0] xfer = '0;

  // Monitor state.
  int cyc = 0;
  bit seg_check = 1'b1;
  bit seg_open = 1'b0;
  int seg_id, seg_beats;
  int wr_first, wr_last, wr_cnt, full_stall;
  int wait_cnt[NUM_REQ];
  int max_wait[NUM_REQ];

  task automatic load(input int id, input int n);
    logic [DWIDTH-1:0] d;
    for (int k = 0; k < n; k++) begin
      d = {4'(id), 12'h000, 16'(seq)};
      seq++;
      src_q[id].push_back(d);
      exp_q[id].push_back(d);
    end
  endtask

  task automatic push_seg(input int id, input int beats);
    exp_seg_q.push_back(id * 256 + beats);
  endtask

  function automatic int pending();
    int s = 0;
    for (int i = 0; i < NUM_REQ; i++) s += src_q[i].size();
    return s;
  endfunction

  function automatic int exp_left();
    int s = 0;
    for (int i = 0; i < NUM_REQ; i++) s += exp_q[i].size();
    return s;
  endfunction

  task automatic close_seg();
    int e;
    bit have;
    seg_open = 1'b0;
    if (seg_check) begin
      have = (exp_seg_q.size() != 0);
      check_eq("seg_expected", have, 1);
      if (have) begin
        e = exp_seg_q.pop_front();
        check_eq("seg_id", seg_id, e / 256);
        check_eq("seg_beats", seg_beats, e % 256);
      end
    end
  endtask

  // Driver: retire accepted beats, present the next item per requester, drive full.
  initial begin : driver
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (xfer[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
        if (src_q[i].size() != 0 && int'($urandom_range(99)) < gate_pct) begin
          req_valid[i] = 1'b1;
          req_data[i*DWIDTH +: DWIDTH] = src_q[i][0];
        end else begin
          req_valid[i] = 1'b0;
          req_data[i*DWIDTH +: DWIDTH] = '0;
        end
      end
      if (full_script.size() != 0) fifo_wr_full = full_script.pop_front();
      else fifo_wr_full = (int'($urandom_range(99)) < full_pct);
    end
  end

  // Monitor: sample mid-cycle, check protocol and data, track grant segments and waits.
  initial begin : monitor
    logic [NUM_REQ-1:0] xr;
    logic [DWIDTH-1:0]  exp_d;
    int id;
    bit src_ok;
    forever begin
      @(negedge clk);
      cyc++;
      xfer = req_valid & req_ready;
      check_eq("wr_en_vs_xfer", fifo_wr_en, |xfer);
      if (fifo_wr_full) check_eq("wr_en_while_full", fifo_wr_en, 0);
      if (!grant_active || fifo_wr_full) check_eq("ready_blocked", req_ready, 0);
      if (rst) check_eq("grant_in_rst", grant_active, 0);
      if (grant_active && fifo_wr_full) full_stall++;
      if (fifo_wr_en) begin
        wr_cnt++;
        if (wr_first < 0) wr_first = cyc;
        wr_last = cyc;
        id = int'(fifo_wr_data[DWIDTH-1 -: 4]);
        src_ok = (id < NUM_REQ) ? (exp_q[id].size() != 0) : 1'b0;
        check_eq("wr_src_known", src_ok, 1);
        if (src_ok) begin
          exp_d = exp_q[id].pop_front();
          check_eq("wr_data", fifo_wr_data, exp_d);
          xr = NUM_REQ'(1) << id;
          check_eq("wr_from_ready", xfer, xr);
        end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!req_valid[i] || xfer[i]) wait_cnt[i] = 0;
        else if (|xfer) wait_cnt[i]++;
        if (wait_cnt[i] > max_wait[i]) max_wait[i] = wait_cnt[i];
      end
      if (seg_open && (!grant_active || int'(grant_id) != seg_id || seg_beats == MAX_BURST)) begin
        close_seg();
      end
      if (grant_active && !seg_open) begin
        seg_open  = 1'b1;
        seg_id    = int'(grant_id);
        seg_beats = 0;
      end
      if (seg_open && fifo_wr_en) seg_beats++;
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #2;
    check_eq("rst_active", grant_active, 0);
    check_eq("rst_grant_id", grant_id, NUM_REQ - 1);
    check_eq("rst_ready", req_ready, 0);
    check_eq("rst_wr_en", fifo_wr_en, 0);
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  task automatic start_test();
    wr_first   = -1;
    wr_last    = -1;
    wr_cnt     = 0;
    full_stall = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      wait_cnt[i] = 0;
      max_wait[i] = 0;
    end
  endtask

  task automatic drain(input int budget);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    while (!done && n < budget) begin
      @(posedge clk);
      #2;
      n++;
      done = (pending() == 0) && !grant_active;
    end
    check_eq("drain_in_budget", done, 1);
    repeat (3) @(posedge clk);
    #2;
    check_eq("sb_left", exp_left(), 0);
    check_eq("seg_left", exp_seg_q.size(), 0);
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [7:0] pat;
    int n;
    rst = 1'b1;
    req_valid = '0;
    req_data = '0;
    fifo_wr_full = 1'b0;

    // All four continuously valid: strict rotation, 4 beats each, no gaps.
    do_reset();
    start_test();
    for (int i = 0; i < NUM_REQ; i++) load(i, 8);
    for (int r = 0; r < 2; r++) for (int i = 0; i < NUM_REQ; i++) push_seg(i, 4);
    push_seg(3, 0);  // sole remaining requester re-wins, then finds itself empty
    @(posedge clk);
    @(negedge clk);
    #1;
    check_eq("lat_idle_cycle", grant_active, 0);
    @(negedge clk);
    #1;
    check_eq("lat_grant", grant_active, 1);
    check_eq("lat_first_id", grant_id, 0);
    drain(500);
    check_eq("rot_wr_cnt", wr_cnt, 32);
    check_eq("rot_wr_span", wr_last - wr_first + 1, 32);

    // Lone requester 2 with 10 beats: 4,4,2 with no bubble.
    do_reset();
    start_test();
    load(2, 10);
    push_seg(2, 4);
    push_seg(2, 4);
    push_seg(2, 2);
    drain(500);
    check_eq("solo_wr_cnt", wr_cnt, 10);
    check_eq("solo_wr_span", wr_last - wr_first + 1, 10);

    // Full stall of 5 cycles after beat 2 of requester 1.
    do_reset();
    start_test();
    load(1, 4);
    pat = 8'b1111_1000;
    for (int k = 0; k < 8; k++) full_script.push_back(pat[k]);
    push_seg(1, 4);
    push_seg(1, 0);
    drain(500);
    check_eq("stall_cycles", full_stall, 5);
    check_eq("stall_wr_cnt", wr_cnt, 4);
    check_eq("stall_wr_span", wr_last - wr_first + 1, 9);

    // Requester 0 drops after one beat; grant moves to 3 with a fresh beat count.
    do_reset();
    start_test();
    load(0, 1);
    load(3, 5);
    push_seg(0, 1);
    push_seg(3, 4);
    push_seg(3, 1);
    drain(500);
    check_eq("drop_wr_span", wr_last - wr_first + 1, 7);

    // Reset pulsed while requester 1 sits at beat 2.
    do_reset();
    start_test();
    load(1, 4);
    push_seg(1, 2);
    push_seg(0, 2);
    push_seg(1, 2);
    n = 0;
    while (src_q[1].size() > 2 && n < 20) begin
      @(posedge clk);
      #2;
      n++;
    end
    check_eq("mid_reach_beat2", src_q[1].size(), 2);
    #1;
    rst = 1'b1;
    #1;
    check_eq("mid_rst_ready", req_ready, 0);
    check_eq("mid_rst_wr_en", fifo_wr_en, 0);
    check_eq("mid_rst_active", grant_active, 0);
    load(0, 2);
    @(posedge clk);
    #2;
    @(posedge clk);
    #2;
    check_eq("mid_rst_hold", grant_active, 0);
    rst = 1'b0;
    drain(500);

    // Randomized valid gating and full back-pressure.
    do_reset();
    start_test();
    seg_check = 1'b0;
    gate_pct = 80;
    full_pct = 25;
    for (int i = 0; i < NUM_REQ; i++) load(i, int'($urandom_range(40, 20)));
    drain(5000);
    for (int i = 0; i < NUM_REQ; i++) begin
      check_eq("fairness_excess_wait", (max_wait[i] > BOUND) ? max_wait[i] : 0, 0);
    end
    gate_pct = 100;
    full_pct = 0;
    seg_check = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of write requesters, legal range 2..16.
REQ-002 Parameter DWIDTH, default 32: data width per requester and of the FIFO write port.
REQ-003 Parameter MAX_BURST, default 4: maximum beats accepted per grant, legal range 1..256.
REQ-004 One clock; reset is asynchronous and active-high. The ports are named clk and rst.
REQ-005 clk  input  1  sole clock; all state is updated on its rising edge.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 req_data  input  NUM_REQ*DWIDTH  per-requester data; requester i occupies bits [i*DWIDTH +: DWIDTH].
REQ-008 req_valid  input  NUM_REQ  per-requester data-valid.
REQ-009 req_ready  output  NUM_REQ  per-requester acceptance; a beat transfers when req_valid[i] & req_ready[i].
REQ-010 fifo_wr_data  output  DWIDTH  data to the shared sync FIFO wr_data.
REQ-011 fifo_wr_en  output  1  write strobe to the shared sync FIFO wr_en.
REQ-012 fifo_wr_full  input  1  wr_full from the shared sync FIFO.
REQ-013 grant_active  output  1  high while the block is in GRANT.
REQ-014 grant_id  output  $clog2(NUM_REQ)  index of the current grantee; holds the last grantee while in IDLE.

Function
REQ-015 The block SHALL implement a two-state FSM, IDLE and GRANT, and grant_active SHALL equal (state==GRANT).
REQ-016 In IDLE with any req_valid bit set, the block SHALL select a winner round-robin and enter GRANT on the next edge (1-cycle arbitration latency).
REQ-017 Round-robin priority: search order starts at last_grant+1 and wraps modulo NUM_REQ; last_grant has the lowest priority.
REQ-018 req_ready[i] SHALL be combinational and equal (state==GRANT) & (grant_id==i) & ~fifo_wr_full; every other bit SHALL be 0.
REQ-019 fifo_wr_en SHALL equal req_valid[grant_id] & req_ready[grant_id], and SHALL never assert when fifo_wr_full=1.
REQ-020 fifo_wr_data SHALL equal the req_data slice of grant_id in every cycle; its value is don't-care when fifo_wr_en=0.
REQ-021 beat_cnt (width $clog2(MAX_BURST+1)) SHALL increment only on accepted beats and clear on every new grant.
REQ-022 Cycles stalled by fifo_wr_full SHALL NOT count as beats, SHALL NOT release the grant, and SHALL have no timeout.
REQ-023 The grant SHALL be released on the edge at which the MAX_BURST-th beat is accepted, or in any GRANT cycle with req_valid[grant_id]=0.
REQ-024 On release: last_grant <= grant_id. If any req_valid bit is set in the release cycle, the block SHALL re-arbitrate in that cycle (REQ-017, using the new last_grant) and stay in GRANT with the new winner, with no idle bubble. Otherwise the next state SHALL be IDLE.
REQ-025 The current grantee SHALL win re-arbitration only when it is the sole requester.
REQ-026 A requester that drops req_valid mid-burst SHALL lose the grant; no beat is lost, because no transfer occurred in that cycle.
REQ-027 Worst-case wait for a continuously valid requester SHALL be (NUM_REQ-1)*MAX_BURST accepted beats plus any full-stall cycles.

Reset
REQ-028 On rst assertion, state SHALL go to IDLE, beat_cnt to 0, last_grant to NUM_REQ-1 and grant_id to NUM_REQ-1, so requester 0 has first priority.
REQ-029 During reset, req_ready, fifo_wr_en and grant_active SHALL be 0, and no beat SHALL be accepted.
REQ-030 Reset asserted mid-burst SHALL abort the grant immediately; after reset deassertion, arbitration SHALL restart per REQ-016.

Structure
REQ-031 The FSM state enum typedef (IDLE, GRANT) SHALL reside in the shared package easy_fifo_pkg.
REQ-032 The combinational round-robin picker (inputs: request vector and last_grant; outputs: winner index and any-valid flag) SHALL be a sub-module named rr_pick.
REQ-033 The FSM, beat counter and last_grant register SHALL reside in fifo_wr_arbiter; the block SHALL connect directly to sync_fifo write ports.

Verification
REQ-034 Defaults, all four requesters continuously valid, fifo never full -> grants in order 0,1,2,3,0, 4 beats each, and fifo_wr_en high every cycle after the first grant.
REQ-035 Only requester 2 valid, for 10 beats -> grants of 4,4,2 beats to requester 2 with no bubble, then IDLE.
REQ-036 Requester 1 granted; fifo_wr_full held high for 5 cycles after beat 2 -> req_ready low and fifo_wr_en low for 5 cycles; beats 3 and 4 are then accepted and the grant is released.
REQ-037 Requester 0 drops req_valid after 1 beat while requester 3 is valid -> grant moves to 3 on the next edge and beat_cnt restarts at 0.
REQ-038 rst pulsed while requester 1 is at beat 2 -> outputs drop to 0 immediately; after release, the first grant goes to requester 0 if it is valid.
REQ-039 Randomized cross-check against a sync_fifo scoreboard -> per-requester order preserved, no beat lost or duplicated, fairness bound of REQ-027 met.
